register_pipe: RTL and testbench

- Parametrised successor to the single clock-enabled register: a chain of DEPTH register stages carrying CHANNELS words per beat, with valid/ready flow control and bubble collapsing.
- Sits between compute stages that need fixed retiming plus backpressure tolerance, e.g. between PE array output and the output packer.
- Holds up to DEPTH beats. Reports occupancy. Honours a global clock_enable freeze.

---
 rtl/register_pipe_pkg.sv | 19 +
 rtl/register_pipe_stage.sv | 43 ++++
 rtl/register_pipe.sv | 80 ++++++++
 tb/tb_register_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/register_pipe_pkg.sv
// Shared helpers for the register_pipe slice: channel slicing and occupancy counter sizing.
package register_pipe_pkg;

    localparam int DEFAULT_WORD_WIDTH  = 8;
    localparam int DEFAULT_CHANNELS    = 2;
    localparam int DEFAULT_DEPTH       = 3;
    localparam int DEFAULT_RESET_VALUE = 8;

    // Bit offset of channel c inside a packed beat.
    function automatic int slice_offset(input int channel, input int word_width);
        return channel * word_width;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// One pipe stage: valid bit plus a full beat of data, loading whenever it is empty or
// downstream can take its current contents.
module register_pipe_stage
    import register_pipe_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           prev_valid,
    input  logic [CHANNELS*WORD_WIDTH-1:0] prev_data,
    input  logic                           next_ready,
    output logic                           valid,
    output logic [CHANNELS*WORD_WIDTH-1:0] data,
    output logic                           ready
);

    localparam int                    BEAT_W     = CHANNELS * WORD_WIDTH;
    localparam logic [WORD_WIDTH-1:0] RESET_WORD = WORD_WIDTH'(RESET_VALUE);

    logic [BEAT_W-1:0] reset_beat;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_reset_word
        assign reset_beat[slice_offset(c, WORD_WIDTH) +: WORD_WIDTH] = RESET_WORD;
    end

    // An empty stage always loads, which is what collapses bubbles under a stall.
    assign ready = ~valid | next_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= reset_beat;
        end else if (enable && ready) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage retiming pipe with valid/ready flow control, bubble collapsing,
// occupancy count and a global clock_enable freeze.
module register_pipe
    import register_pipe_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           clock_enable,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [CHANNELS*WORD_WIDTH-1:0] s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CHANNELS*WORD_WIDTH-1:0] m_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int BEAT_W  = CHANNELS * WORD_WIDTH;
    localparam int COUNT_W = count_width(DEPTH);

    logic [DEPTH-1:0]  stage_valid;
    logic [BEAT_W-1:0] stage_data [DEPTH];
    logic [DEPTH:0]    stage_ready;
    logic [DEPTH-1:0]  prev_valid;
    logic [BEAT_W-1:0] prev_data  [DEPTH];
    logic              accept;
    logic              emit;

    assign stage_ready[DEPTH] = m_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign prev_valid[i] = s_valid;
            assign prev_data[i]  = s_data;
        end else begin : g_body
            assign prev_valid[i] = stage_valid[i-1];
            assign prev_data[i]  = stage_data[i-1];
        end

        register_pipe_stage #(
            .WORD_WIDTH (WORD_WIDTH),
            .CHANNELS   (CHANNELS),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clock     (clock),
            .resetn    (resetn),
            .enable    (clock_enable),
            .prev_valid(prev_valid[i]),
            .prev_data (prev_data[i]),
            .next_ready(stage_ready[i+1]),
            .valid     (stage_valid[i]),
            .data      (stage_data[i]),
            .ready     (stage_ready[i])
        );
    end

    // Gating both handshake outputs with clock_enable keeps a frozen pipe from trading beats.
    assign s_ready = clock_enable & stage_ready[0];
    assign m_valid = clock_enable & stage_valid[DEPTH-1];
    assign m_data  = stage_data[DEPTH-1];

    assign accept = s_valid & s_ready;
    assign emit   = m_valid & m_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (accept && !emit) begin
            count <= count + COUNT_W'(1);
        end else if (emit && !accept) begin
            count <= count - COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_register_pipe.sv
// Directed bench for register_pipe (WORD_WIDTH=8, CHANNELS=2, DEPTH=3, RESET_VALUE=8).
module tb_register_pipe;

    logic        clock;
    logic        resetn;
    logic        clock_enable;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    register_pipe #(
        .WORD_WIDTH (8),
        .CHANNELS   (2),
        .DEPTH      (3),
        .RESET_VALUE(8)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .clock_enable(clock_enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        ce;
        logic        sv;
        logic [15:0] sd;
        logic        mr;
        logic        chk;
        logic        e_sr;
        logic        e_mv;
        logic        e_dchk;
        logic [15:0] e_data;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[20];

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic applyStimulus(input logic rst_n, input logic ce, input logic sv,
                                 input logic [15:0] sd, input logic mr);
        resetn       = rst_n;
        clock_enable = ce;
        s_valid      = sv;
        s_data       = sd;
        m_ready      = mr;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic e_sr, input logic e_mv,
                               input logic e_dchk, input logic [15:0] e_data,
                               input logic [1:0] e_cnt);
        total++;
        if (s_ready !== e_sr) begin
            bad++;
            $display("[TB] FAIL %s s_ready: got %b want %b", name, s_ready, e_sr);
        end
        total++;
        if (m_valid !== e_mv) begin
            bad++;
            $display("[TB] FAIL %s m_valid: got %b want %b", name, m_valid, e_mv);
        end
        total++;
        if (count !== e_cnt) begin
            bad++;
            $display("[TB] FAIL %s count: got %0d want %0d", name, count, e_cnt);
        end
        if (e_dchk) begin
            total++;
            if (m_data !== e_data) begin
                bad++;
                $display("[TB] FAIL %s m_data: got %h want %h", name, m_data, e_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string name, input logic rst_n, input logic ce, input logic sv,
                        input logic [15:0] sd, input logic mr, input logic e_sr,
                        input logic e_mv, input logic e_dchk, input logic [15:0] e_data,
                        input logic [1:0] e_cnt);
        applyStimulus(rst_n, ce, sv, sd, mr);
        checkOutput(name, e_sr, e_mv, e_dchk, e_data, e_cnt);
        tick();
    endtask

    initial begin
        //            rst ce sv  sd        mr chk sr mv dchk data      cnt
        vecs[0]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,2'd0};
        vecs[1]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b1,16'h0808,2'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,1'b1,16'h0808,2'd0};
        vecs[3]  = '{1'b1,1'b1,1'b1,16'h0105,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0};
        vecs[4]  = '{1'b1,1'b1,1'b1,16'h0208,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd1};
        vecs[5]  = '{1'b1,1'b1,1'b1,16'h0309,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd2};
        vecs[6]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h0105,2'd3};
        vecs[7]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h0208,2'd2};
        vecs[8]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h0309,2'd1};
        vecs[9]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0};
        vecs[10] = '{1'b1,1'b1,1'b1,16'h000A,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0};
        vecs[11] = '{1'b1,1'b1,1'b1,16'h000B,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd1};
        vecs[12] = '{1'b1,1'b1,1'b1,16'h000C,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd2};
        vecs[13] = '{1'b1,1'b1,1'b1,16'h000D,1'b0,1'b1,1'b0,1'b1,1'b1,16'h000A,2'd3};
        vecs[14] = '{1'b1,1'b1,1'b1,16'h000D,1'b0,1'b1,1'b0,1'b1,1'b1,16'h000A,2'd3};
        vecs[15] = '{1'b1,1'b1,1'b1,16'h000D,1'b1,1'b1,1'b1,1'b1,1'b1,16'h000A,2'd3};
        vecs[16] = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h000B,2'd3};
        vecs[17] = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h000C,2'd2};
        vecs[18] = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,1'b1,16'h000D,2'd1};
        vecs[19] = '{1'b1,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0};

        resetn = 1'b0; clock_enable = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].ce, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            if (vecs[i].chk)
                checkOutput($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_mv,
                            vecs[i].e_dchk, vecs[i].e_data, vecs[i].e_cnt);
            tick();
        end

        // Bubble collapse: second beat two cycles behind the first, downstream stalled.
        step("bub_a",   1, 1, 1, 16'h1111, 0, 1, 0, 0, 16'h0000, 2'd0);
        step("bub_gap", 1, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 2'd1);
        step("bub_b",   1, 1, 1, 16'h2222, 0, 1, 0, 0, 16'h0000, 2'd1);
        step("bub_h1",  1, 1, 0, 16'h0000, 0, 1, 1, 1, 16'h1111, 2'd2);
        step("bub_h2",  1, 1, 0, 16'h0000, 0, 1, 1, 1, 16'h1111, 2'd2);
        step("bub_o1",  1, 1, 0, 16'h0000, 1, 1, 1, 1, 16'h1111, 2'd2);
        step("bub_o2",  1, 1, 0, 16'h0000, 1, 1, 1, 1, 16'h2222, 2'd1);
        step("bub_end", 1, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'd0);

        // Freeze with two beats in flight while both sides want to handshake.
        step("frz_a",   1, 1, 1, 16'h3333, 1, 1, 0, 0, 16'h0000, 2'd0);
        step("frz_b",   1, 1, 1, 16'h4444, 1, 1, 0, 0, 16'h0000, 2'd1);
        for (int k = 0; k < 4; k++)
            step($sformatf("frz_hold%0d", k), 1, 0, 1, 16'h5555, 1, 0, 0, 0, 16'h0000, 2'd2);
        step("frz_r0",  1, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'd2);
        step("frz_o1",  1, 1, 0, 16'h0000, 1, 1, 1, 1, 16'h3333, 2'd2);
        step("frz_o2",  1, 1, 0, 16'h0000, 1, 1, 1, 1, 16'h4444, 2'd1);
        step("frz_end", 1, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 2'd0);

        // Reset while full; the beat offered during reset must not be captured.
        step("rst_f1",  1, 1, 1, 16'h6661, 0, 1, 0, 0, 16'h0000, 2'd0);
        step("rst_f2",  1, 1, 1, 16'h6662, 0, 1, 0, 0, 16'h0000, 2'd1);
        step("rst_f3",  1, 1, 1, 16'h6663, 0, 1, 0, 0, 16'h0000, 2'd2);
        step("rst_full",1, 1, 0, 16'h0000, 0, 0, 1, 1, 16'h6661, 2'd3);
        applyStimulus(0, 1, 1, 16'h0B0B, 0);
        tick();
        step("rst_post",1, 1, 0, 16'h0000, 0, 1, 0, 1, 16'h0808, 2'd0);
        step("rst_q1",  1, 1, 0, 16'h0000, 0, 1, 0, 1, 16'h0808, 2'd0);
        step("rst_q2",  1, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 2'd0);
        step("rst_q3",  1, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
